// File: rtl/execute_if.sv
// Bundle of the execute stage's fetch handshake, program-RAM bus and
// architectural status outputs. The master side is the execute stage.
interface execute_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          ir_valid;
  logic [DW-1:0] ir;
  logic          ir_ready;
  logic          pc_load;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] acc;
  logic          zf;
  logic          cf;
  logic          halted;

  modport master (
    input  ir_valid, ir, mem_rdata,
    output ir_ready, pc_load, pc_d, mem_addr, mem_we, mem_wdata,
           acc, zf, cf, halted
  );

  modport slave (
    output ir_valid, ir, mem_rdata,
    input  ir_ready, pc_load, pc_d, mem_addr, mem_we, mem_wdata,
           acc, zf, cf, halted
  );
endinterface

// File: rtl/execute.sv
// Execute stage: accepts one instruction word at a time from fetch, decodes
// opcode[15:12] + addr[11:0], runs it against a synchronous single-port
// program RAM, keeps the accumulator and Z/C flags, and redirects fetch on
// taken jumps. The all-ones word halts the stage until reset.
module execute #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input logic    clk,
  input logic    rst_n,
  execute_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    MEMRD  = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_opreg;
  logic [DW-1:0] r_acc;
  logic          r_zf;
  logic          r_cf;
  logic          r_halted;

  logic [3:0]    w_op;
  logic          w_haltWord;
  logic          w_accept;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_and;

  assign w_op       = r_opreg[DW-1:DW-4];
  assign w_haltWord = (r_opreg == {DW{1'b1}});
  assign w_accept   = bus.ir_valid && (r_state == IDLE);

  // The top bit of the 17-bit sum is the carry; of the difference, the borrow.
  assign w_sum  = {1'b0, r_acc} + {1'b0, bus.mem_rdata};
  assign w_diff = {1'b0, r_acc} - {1'b0, bus.mem_rdata};
  assign w_and  = r_acc & bus.mem_rdata;

  // The operand address and jump target both come straight from the held word.
  assign bus.mem_addr  = r_opreg[AW-1:0];
  assign bus.pc_d      = r_opreg[AW-1:0];
  assign bus.mem_wdata = r_acc;
  assign bus.acc       = r_acc;
  assign bus.zf        = r_zf;
  assign bus.cf        = r_cf;
  assign bus.halted    = r_halted;

  // State register; reset returns to IDLE and aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode from the current state and the held word.
  always_comb begin
    w_next       = r_state;
    bus.ir_ready = 1'b0;
    bus.pc_load  = 1'b0;
    bus.mem_we   = 1'b0;
    case (r_state)
      IDLE: begin
        bus.ir_ready = 1'b1;
        if (bus.ir_valid) begin
          w_next = DECODE;
        end
      end
      DECODE: begin
        w_next = IDLE;
        if (w_haltWord) begin
          w_next = HALT;
        end else begin
          case (w_op)
            OP_LD, OP_ADD, OP_SUB, OP_AND: w_next = MEMRD;
            OP_ST:  bus.mem_we  = 1'b1;
            OP_JMP: bus.pc_load = 1'b1;
            OP_JZ:  bus.pc_load = r_zf;
            default: w_next = IDLE;
          endcase
        end
      end
      MEMRD: begin
        w_next = IDLE;
      end
      HALT: begin
        w_next = HALT;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the accepted word, set the sticky halt, and retire
  // memory-operand instructions on the edge that leaves MEMRD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opreg  <= '0;
      r_acc    <= '0;
      r_zf     <= 1'b0;
      r_cf     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opreg <= bus.ir;
      end
      if (r_state == DECODE && w_haltWord) begin
        r_halted <= 1'b1;
      end
      if (r_state == MEMRD) begin
        case (w_op)
          OP_LD: begin
            r_acc <= bus.mem_rdata;
            r_zf  <= (bus.mem_rdata == '0);
          end
          OP_ADD: begin
            r_acc <= w_sum[DW-1:0];
            r_cf  <= w_sum[DW];
            r_zf  <= (w_sum[DW-1:0] == '0);
          end
          OP_SUB: begin
            r_acc <= w_diff[DW-1:0];
            r_cf  <= w_diff[DW];
            r_zf  <= (w_diff[DW-1:0] == '0);
          end
          OP_AND: begin
            r_acc <= w_and;
            r_zf  <= (w_and == '0);
          end
          default: begin
            r_acc <= r_acc;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: a synchronous RAM model, a
// behavioural instruction-level reference model, directed scenarios and a
// randomized instruction stream.
module tb_execute;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  execute_if #(.AW(AW), .DW(DW)) bus ();
  execute #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Synchronous program RAM with a bench-side preload port.
  logic [15:0] ram [0:4095];
  logic        pokeEn = 1'b0;
  logic [11:0] pokeAddr = '0;
  logic [15:0] pokeData = '0;

  // One-cycle read latency; preload takes priority over DUT writes.
  always @(posedge clk) begin
    if (pokeEn) ram[pokeAddr] <= pokeData;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference model state: architectural registers and memory image.
  logic [15:0] mAcc = '0;
  logic        mZf = 1'b0;
  logic        mCf = 1'b0;
  logic [15:0] mMem [0:4095];

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    mMem[a] = d;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  // Instruction-level model: what one word does to acc/flags/memory and
  // which strobes and how many busy cycles fetch should see.
  task automatic modelStep(input logic [15:0] w, output int expBusy,
                           output int expPl, output int expWe,
                           output logic [15:0] expWeData);
    int op;
    int a;
    int s;
    op = int'(w) / 4096;
    a  = int'(w) % 4096;
    expBusy = 1; expPl = 0; expWe = 0; expWeData = mAcc;
    case (op)
      1: begin mAcc = mMem[a]; mZf = (mAcc == 0); expBusy = 2; end
      2: begin mMem[a] = mAcc; expWe = 1; end
      3: begin
        s = int'(mAcc) + int'(mMem[a]);
        mCf = (s >= 65536); mAcc = 16'(s % 65536); mZf = (mAcc == 0); expBusy = 2;
      end
      4: begin
        mCf = (mMem[a] > mAcc);
        s = int'(mAcc) - int'(mMem[a]);
        if (s < 0) s = s + 65536;
        mAcc = 16'(s); mZf = (mAcc == 0); expBusy = 2;
      end
      5: begin mAcc = mAcc & mMem[a]; mZf = (mAcc == 0); expBusy = 2; end
      6: expPl = 1;
      7: expPl = mZf ? 1 : 0;
      default: expBusy = 1;
    endcase
  endtask

  // Present a word, wait for acceptance, then watch the busy cycles.
  task automatic applyStimulus(input logic [15:0] word, output int busy,
                               output int plCnt, output logic [11:0] plAddr,
                               output int weCnt, output logic [11:0] weAddr,
                               output logic [15:0] weData);
    int waitCnt;
    busy = 0; plCnt = 0; weCnt = 0; plAddr = '0; weAddr = '0; weData = '0;
    @(negedge clk);
    bus.ir_valid = 1'b1; bus.ir = word;
    waitCnt = 0;
    while (bus.ir_ready !== 1'b1 && waitCnt < 20) begin
      @(negedge clk); waitCnt++;
    end
    if (waitCnt >= 20) begin
      vectors++; miscompares++;
      $display("[TB] FAIL accept_timeout: ir_ready=%b required 1", bus.ir_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.ir_valid = 1'b0;
    while (bus.ir_ready !== 1'b1 && busy < 10) begin
      if (bus.pc_load === 1'b1) begin plCnt++; plAddr = bus.pc_d; end
      if (bus.mem_we === 1'b1) begin
        weCnt++; weAddr = bus.mem_addr; weData = bus.mem_wdata;
      end
      @(negedge clk); busy++;
    end
  endtask

  task automatic test_reset();
    bus.ir_valid = 1'b0; bus.ir = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.mem_we !== 1'b0 || bus.pc_load !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL strobes_in_reset: we=%b pl=%b required 0/0", bus.mem_we, bus.pc_load);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.acc !== 16'h0 || bus.zf !== 1'b0 || bus.cf !== 1'b0 || bus.halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: acc=%h zf=%b cf=%b halted=%b required 0000/0/0/0",
               bus.acc, bus.zf, bus.cf, bus.halted);
    end
    vectors++;
    if (bus.ir_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: ir_ready=%b required 1", bus.ir_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.mem_we !== 1'b0 || bus.pc_load !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_strobes: we=%b pl=%b required 0/0", bus.mem_we, bus.pc_load);
      end
    end
    mAcc = '0; mZf = 1'b0; mCf = 1'b0;
  endtask

  task automatic test_sub_borrow();
    int busy, pl, we, eb, ep, ew;
    logic [11:0] pa, wa;
    logic [15:0] wd, ed;
    poke(12'h010, 16'h0005);
    poke(12'h011, 16'h0003);
    modelStep(16'h1010, eb, ep, ew, ed);
    applyStimulus(16'h1010, busy, pl, pa, we, wa, wd);
    vectors++;
    if (busy != 2 || bus.acc !== 16'h0005) begin
      miscompares++;
      $display("[TB] FAIL ld_basic: busy=%0d acc=%h required 2/0005", busy, bus.acc);
    end
    modelStep(16'h4011, eb, ep, ew, ed);
    applyStimulus(16'h4011, busy, pl, pa, we, wa, wd);
    vectors++;
    if (bus.acc !== 16'h0002 || bus.cf !== 1'b0 || bus.zf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sub_noborrow: acc=%h cf=%b zf=%b required 0002/0/0", bus.acc, bus.cf, bus.zf);
    end
    modelStep(16'h4010, eb, ep, ew, ed);
    applyStimulus(16'h4010, busy, pl, pa, we, wa, wd);
    vectors++;
    if (bus.acc !== 16'hFFFD || bus.cf !== 1'b1 || bus.zf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sub_borrow: acc=%h cf=%b zf=%b required FFFD/1/0", bus.acc, bus.cf, bus.zf);
    end
  endtask

  task automatic test_add_jz();
    int busy, pl, we, eb, ep, ew;
    logic [11:0] pa, wa;
    logic [15:0] wd, ed;
    poke(12'h030, 16'hFFFF);
    poke(12'h031, 16'h0001);
    modelStep(16'h1030, eb, ep, ew, ed);
    applyStimulus(16'h1030, busy, pl, pa, we, wa, wd);
    modelStep(16'h3031, eb, ep, ew, ed);
    applyStimulus(16'h3031, busy, pl, pa, we, wa, wd);
    vectors++;
    if (bus.acc !== 16'h0000 || bus.cf !== 1'b1 || bus.zf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add_wrap: acc=%h cf=%b zf=%b required 0000/1/1", bus.acc, bus.cf, bus.zf);
    end
    modelStep(16'h7123, eb, ep, ew, ed);
    applyStimulus(16'h7123, busy, pl, pa, we, wa, wd);
    vectors++;
    if (pl != 1 || pa !== 12'h123 || we != 0 || busy != 1) begin
      miscompares++;
      $display("[TB] FAIL jz_taken: pl=%0d pc_d=%h we=%0d busy=%0d required 1/123/0/1", pl, pa, we, busy);
    end
  endtask

  task automatic test_store();
    int busy, pl, we, eb, ep, ew;
    logic [11:0] pa, wa;
    logic [15:0] wd, ed;
    poke(12'h032, 16'hABCD);
    modelStep(16'h1032, eb, ep, ew, ed);
    applyStimulus(16'h1032, busy, pl, pa, we, wa, wd);
    modelStep(16'h2020, eb, ep, ew, ed);
    applyStimulus(16'h2020, busy, pl, pa, we, wa, wd);
    vectors++;
    if (we != 1 || wa !== 12'h020 || wd !== 16'hABCD || pl != 0) begin
      miscompares++;
      $display("[TB] FAIL st_write: we=%0d addr=%h wdata=%h pl=%0d required 1/020/ABCD/0", we, wa, wd, pl);
    end
    modelStep(16'h1031, eb, ep, ew, ed);
    applyStimulus(16'h1031, busy, pl, pa, we, wa, wd);
    modelStep(16'h1020, eb, ep, ew, ed);
    applyStimulus(16'h1020, busy, pl, pa, we, wa, wd);
    vectors++;
    if (bus.acc !== 16'hABCD) begin
      miscompares++;
      $display("[TB] FAIL st_readback: acc=%h required ABCD", bus.acc);
    end
  endtask

  task automatic test_random();
    int busy, pl, we, eb, ep, ew, op, a;
    logic [11:0] pa, wa;
    logic [15:0] wd, ed, w;
    for (int i = 0; i < 8; i++) begin
      poke(12'(12'h040 + i), (i == 7) ? 16'h0000 : 16'($urandom_range(0, 65535)));
    end
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 15);
      if (op >= 1 && op <= 5) a = 'h040 + $urandom_range(0, 7);
      else a = $urandom_range(0, 4095);
      if (op == 15 && a == 4095) a = 4094;
      w = 16'(op * 4096 + a);
      modelStep(w, eb, ep, ew, ed);
      applyStimulus(w, busy, pl, pa, we, wa, wd);
      vectors++;
      if (bus.acc !== mAcc || bus.zf !== mZf || bus.cf !== mCf) begin
        miscompares++;
        $display("[TB] FAIL rand_regs word=%h: acc=%h zf=%b cf=%b required %h/%b/%b",
                 w, bus.acc, bus.zf, bus.cf, mAcc, mZf, mCf);
      end
      vectors++;
      if (busy != eb || pl != ep || we != ew) begin
        miscompares++;
        $display("[TB] FAIL rand_timing word=%h: busy=%0d pl=%0d we=%0d required %0d/%0d/%0d",
                 w, busy, pl, we, eb, ep, ew);
      end
      vectors++;
      if ((ep == 1 && pa !== 12'(a)) || (ew == 1 && (wa !== 12'(a) || wd !== ed))) begin
        miscompares++;
        $display("[TB] FAIL rand_target word=%h: pc_d=%h addr=%h wdata=%h required %h/%h/%h",
                 w, pa, wa, wd, 12'(a), 12'(a), ed);
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] saved;
    saved = mAcc;
    @(negedge clk);
    bus.ir_valid = 1'b1; bus.ir = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.ir_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.halted !== 1'b1 || bus.ir_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL halt_enter: halted=%b ir_ready=%b required 1/0", bus.halted, bus.ir_ready);
    end
    bus.ir_valid = 1'b1; bus.ir = 16'h1010;
    repeat (6) @(negedge clk);
    bus.ir_valid = 1'b0;
    vectors++;
    if (bus.acc !== saved || bus.ir_ready !== 1'b0 || bus.halted !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL halt_ignores: acc=%h ir_ready=%b halted=%b required %h/0/1",
               bus.acc, bus.ir_ready, bus.halted, saved);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.halted !== 1'b0 || bus.acc !== 16'h0 || bus.ir_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL halt_reset: halted=%b acc=%h ir_ready=%b required 0/0000/1",
               bus.halted, bus.acc, bus.ir_ready);
    end
    mAcc = '0; mZf = 1'b0; mCf = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [5];
    int busy, pl, we, eb, ep, ew;
    logic [15:0] ed;
    words = '{16'h1040, 16'h3041, 16'h2042, 16'h6055, 16'h5043};
    for (int i = 0; i < 4; i++) poke(12'(12'h040 + i), 16'($urandom_range(1, 65535)));
    @(negedge clk);
    bus.ir_valid = 1'b1; bus.ir = words[0];
    for (int i = 0; i < 5; i++) begin
      modelStep(words[i], eb, ep, ew, ed);
      vectors++;
      if (bus.ir_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready_high[%0d]: ir_ready=%b required 1", i, bus.ir_ready);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.ir_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready_fall[%0d]: ir_ready=%b required 0", i, bus.ir_ready);
      end
      if (i < 4) bus.ir = words[i+1];
      else bus.ir_valid = 1'b0;
      busy = 0; pl = 0; we = 0;
      while (bus.ir_ready !== 1'b1 && busy < 10) begin
        if (bus.pc_load === 1'b1) pl++;
        if (bus.mem_we === 1'b1) we++;
        @(negedge clk); busy++;
      end
      vectors++;
      if (busy != eb || pl != ep || we != ew) begin
        miscompares++;
        $display("[TB] FAIL b2b_timing[%0d]: busy=%0d pl=%0d we=%0d required %0d/%0d/%0d",
                 i, busy, pl, we, eb, ep, ew);
      end
    end
    vectors++;
    if (bus.acc !== mAcc || bus.zf !== mZf || bus.cf !== mCf) begin
      miscompares++;
      $display("[TB] FAIL b2b_result: acc=%h zf=%b cf=%b required %h/%b/%b",
               bus.acc, bus.zf, bus.cf, mAcc, mZf, mCf);
    end
    // Reset during MEMRD of a load must leave acc at zero.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mAcc = '0; mZf = 1'b0; mCf = 1'b0;
    @(negedge clk);
    bus.ir_valid = 1'b1; bus.ir = 16'h1010;
    @(posedge clk);
    @(negedge clk);
    bus.ir_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.acc !== 16'h0 || bus.mem_we !== 1'b0 || bus.pc_load !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_in_reset: acc=%h we=%b pl=%b required 0000/0/0",
               bus.acc, bus.mem_we, bus.pc_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.acc !== 16'h0 || bus.ir_ready !== 1'b1 || bus.halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_after: acc=%h ir_ready=%b halted=%b required 0000/1/0",
               bus.acc, bus.ir_ready, bus.halted);
    end
  endtask

  // Run the scenarios in order and report.
  initial begin
    bus.ir_valid = 1'b0;
    bus.ir = '0;
    test_reset();
    test_sub_borrow();
    test_add_jz();
    test_store();
    test_random();
    test_halt();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
